// File: rtl/simon_pkg.sv
// Shared types and widths for the Simon Says game sequencer.
package simon_pkg;

    localparam int unsigned ROUND_W   = 6;
    localparam int unsigned SPEED_W   = 3;
    localparam int unsigned SPEED_MAX = 7;

    typedef enum logic [3:0] {
        IDLE,
        SEED,
        SETUP,
        REWIND,
        SHOW_ON,
        SHOW_OFF,
        P_REWIND,
        P_LOAD,
        PLAYER,
        CHECK,
        WIN,
        LOSE
    } state_t;

endpackage

// File: rtl/simon_speed_sched.sv
// Flash speed scheduler: maps the finished round count to a saturated speed code.
module simon_speed_sched
    import simon_pkg::*;
#(
    parameter int unsigned SPEED_STEP = 4,
    parameter int unsigned INIT_SPEED = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               update,
    input  logic [ROUND_W-1:0] round_in,
    output logic [SPEED_W-1:0] speed
);

    logic [7:0] sum_c;

    // One speed step per SPEED_STEP completed rounds, on top of the base code
    assign sum_c = 8'(INIT_SPEED) + 8'(round_in) / 8'(SPEED_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed <= SPEED_W'(INIT_SPEED);
        end else if (clear) begin
            speed <= SPEED_W'(INIT_SPEED);
        end else if (update) begin
            speed <= (sum_c > 8'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX) : sum_c[SPEED_W-1:0];
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: seed capture, per-round replay, player entry, win/lose.
// Every output is registered from the next-state decode, so pulses coincide with state entry.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_ROUND      = 32,
    parameter int unsigned SPEED_STEP     = 4,
    parameter int unsigned INIT_SPEED     = 0,
    parameter int unsigned TIMEOUT_PULSES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               press_valid,
    input  logic               pulse,
    input  logic               result,
    output logic               start,
    output logic               load_colour,
    output logic               load_speed,
    output logic               rst_seedgen,
    output logic               player_turn,
    output logic               flash_clk,
    output logic [ROUND_W-1:0] check_round,
    output logic [SPEED_W-1:0] speed,
    output logic [ROUND_W-1:0] round,
    output logic               game_won,
    output logic               game_over
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_PULSES + 1);

    state_t             state, state_nx;
    logic [ROUND_W-1:0] round_nx, check_round_nx, last_idx;
    logic [TO_W-1:0]    to_cnt, to_cnt_nx;
    logic               flash_nx, start_nx, load_colour_nx, load_speed_nx;
    logic               rst_seedgen_nx, player_turn_nx, game_won_nx, game_over_nx;
    logic               speed_clear, speed_update;

    assign last_idx = round - ROUND_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        round_nx       = round;
        check_round_nx = check_round;
        to_cnt_nx      = to_cnt;
        flash_nx       = 1'b0;

        case (state)
            IDLE:     if (go) state_nx = SEED;
            SEED:     state_nx = SETUP;
            SETUP:    state_nx = REWIND;
            REWIND:   state_nx = SHOW_ON;
            SHOW_ON:  if (pulse) state_nx = SHOW_OFF;
            SHOW_OFF: begin
                if (pulse) begin
                    if (check_round == last_idx) begin
                        state_nx = P_REWIND;
                    end else begin
                        check_round_nx = check_round + ROUND_W'(1);
                        state_nx       = SHOW_ON;
                    end
                end
            end
            P_REWIND: state_nx = P_LOAD;
            P_LOAD:   state_nx = PLAYER;
            // A press in the same cycle as the final timeout pulse still counts
            PLAYER: begin
                if (press_valid) begin
                    state_nx = CHECK;
                end else if (pulse) begin
                    if (to_cnt == TO_W'(TIMEOUT_PULSES - 1)) state_nx = LOSE;
                    else                                     to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            CHECK: begin
                if (!result) begin
                    state_nx = LOSE;
                end else if (check_round != last_idx) begin
                    check_round_nx = check_round + ROUND_W'(1);
                    state_nx       = P_LOAD;
                end else if (round == ROUND_W'(MAX_ROUND)) begin
                    state_nx = WIN;
                end else begin
                    state_nx = SETUP;
                end
            end
            WIN, LOSE: begin
                if (go) state_nx = SEED;
                else    flash_nx = flash_clk ^ pulse;
            end
            default: state_nx = IDLE;
        endcase

        // Values that depend only on which state is being entered
        if (state_nx == SEED)  round_nx = '0;
        if (state_nx == SETUP) round_nx = round + ROUND_W'(1);
        if (state_nx == SEED || state_nx == REWIND || state_nx == P_REWIND) check_round_nx = '0;
        if (state_nx != PLAYER)  to_cnt_nx = '0;
        if (state_nx == SHOW_ON) flash_nx  = 1'b1;

        start_nx       = (state_nx == SEED);
        load_speed_nx  = (state_nx == REWIND);
        rst_seedgen_nx = (state_nx == REWIND) || (state_nx == P_REWIND);
        load_colour_nx = ((state_nx == SHOW_ON) && (state != SHOW_ON)) || (state_nx == P_LOAD);
        player_turn_nx = (state_nx == PLAYER);
        game_won_nx    = (state_nx == WIN);
        game_over_nx   = (state_nx == LOSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round       <= '0;
            check_round <= '0;
            to_cnt      <= '0;
            flash_clk   <= 1'b0;
            start       <= 1'b0;
            load_colour <= 1'b0;
            load_speed  <= 1'b0;
            rst_seedgen <= 1'b0;
            player_turn <= 1'b0;
            game_won    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            round       <= round_nx;
            check_round <= check_round_nx;
            to_cnt      <= to_cnt_nx;
            flash_clk   <= flash_nx;
            start       <= start_nx;
            load_colour <= load_colour_nx;
            load_speed  <= load_speed_nx;
            rst_seedgen <= rst_seedgen_nx;
            player_turn <= player_turn_nx;
            game_won    <= game_won_nx;
            game_over   <= game_over_nx;
        end
    end

    // Speed is computed from the round being completed, landing for the REWIND load
    assign speed_clear  = (state_nx == SEED);
    assign speed_update = (state_nx == SETUP);

    simon_speed_sched #(
        .SPEED_STEP(SPEED_STEP),
        .INIT_SPEED(INIT_SPEED)
    ) u_speed_sched (
        .clk     (clk),
        .reset   (reset),
        .clear   (speed_clear),
        .update  (speed_update),
        .round_in(round),
        .speed   (speed)
    );

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl: datapath command pulses are checked against
// a queue of expected events; levels are checked at fixed points in each game.
module tb_simon_game_ctrl;

    localparam int unsigned MAX_ROUND      = 13;
    localparam int unsigned SPEED_STEP     = 4;
    localparam int unsigned INIT_SPEED     = 5;
    localparam int unsigned TIMEOUT_PULSES = 8;

    typedef struct packed {
        logic [3:0] kind;   // {start, load_colour, load_speed, rst_seedgen}
        logic [5:0] cr;
        logic [5:0] rnd;
        logic [2:0] spd;
    } ev_t;

    logic       clk, reset, go, press_valid, pulse, result;
    logic       start, load_colour, load_speed, rst_seedgen, player_turn, flash_clk;
    logic       game_won, game_over;
    logic [5:0] check_round, round;
    logic [2:0] speed;

    ev_t exp_q[$];
    ev_t mon_obs, mon_exp;
    int  n_cmp = 0;
    int  n_err = 0;

    simon_game_ctrl #(
        .MAX_ROUND     (MAX_ROUND),
        .SPEED_STEP    (SPEED_STEP),
        .INIT_SPEED    (INIT_SPEED),
        .TIMEOUT_PULSES(TIMEOUT_PULSES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .press_valid(press_valid),
        .pulse      (pulse),
        .result     (result),
        .start      (start),
        .load_colour(load_colour),
        .load_speed (load_speed),
        .rst_seedgen(rst_seedgen),
        .player_turn(player_turn),
        .flash_clk  (flash_clk),
        .check_round(check_round),
        .speed      (speed),
        .round      (round),
        .game_won   (game_won),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] spd(input int r);
        int s;
        s = int'(INIT_SPEED) + (r - 1) / int'(SPEED_STEP);
        if (s > 7) s = 7;
        return 3'(s);
    endfunction

    function automatic ev_t mk(input logic [3:0] kind, input int cr, input int rnd, input logic [2:0] sp);
        ev_t e;
        e.kind = kind;
        e.cr   = 6'(cr);
        e.rnd  = 6'(rnd);
        e.spd  = sp;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every command pulse seen must be the next one the stimulus predicted
    always @(negedge clk) begin
        if (!reset && (start || load_colour || load_speed || rst_seedgen)) begin
            mon_obs = mk({start, load_colour, load_speed, rst_seedgen}, int'(check_round), int'(round), speed);
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL event_unexpected: observed %h expected none", mon_obs);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                assert (mon_obs === mon_exp) else begin
                    n_err++;
                    $error("FAIL event: observed %h expected %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_pulse();
        pulse = 1'b1; @(negedge clk); pulse = 1'b0;
    endtask

    task automatic do_press();
        press_valid = 1'b1; @(negedge clk); press_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"},  32'(start), 0);
        chk({tag, "_lcol"},   32'(load_colour), 0);
        chk({tag, "_lspd"},   32'(load_speed), 0);
        chk({tag, "_rseed"},  32'(rst_seedgen), 0);
        chk({tag, "_turn"},   32'(player_turn), 0);
        chk({tag, "_flash"},  32'(flash_clk), 0);
        chk({tag, "_cr"},     32'(check_round), 0);
        chk({tag, "_speed"},  32'(speed), INIT_SPEED);
        chk({tag, "_round"},  32'(round), 0);
        chk({tag, "_won"},    32'(game_won), 0);
        chk({tag, "_over"},   32'(game_over), 0);
    endtask

    // From IDLE/WIN/LOSE: go -> SEED; returns at the SETUP cycle
    task automatic start_game();
        exp_q.push_back(mk(4'b1000, 0, 0, 3'(INIT_SPEED)));
        go = 1'b1; @(negedge clk); go = 1'b0;
        chk("seed_start", 32'(start), 1);
        chk("seed_round", 32'(round), 0);
        chk("seed_speed", 32'(speed), INIT_SPEED);
        chk("seed_won",   32'(game_won), 0);
        chk("seed_over",  32'(game_over), 0);
        tick(1);
    endtask

    // From SETUP: replay round r; returns at the first PLAYER cycle
    task automatic replay(input int r, input bit noise);
        exp_q.push_back(mk(4'b0011, 0, r, spd(r)));
        exp_q.push_back(mk(4'b0100, 0, r, spd(r)));
        tick(2);
        chk("show_round", 32'(round), 32'(r));
        chk("show_speed", 32'(speed), 32'(spd(r)));
        for (int i = 0; i < r; i++) begin
            if (noise) begin
                go = 1'b1; press_valid = 1'b1; @(negedge clk); go = 1'b0; press_valid = 1'b0;
                chk("noise_turn", 32'(player_turn), 0);
                chk("noise_cr",   32'(check_round), 32'(i));
            end
            chk("show_on_flash", 32'(flash_clk), 1);
            chk("show_cr",       32'(check_round), 32'(i));
            do_pulse();
            chk("show_off_flash", 32'(flash_clk), 0);
            if (i == r - 1) begin
                exp_q.push_back(mk(4'b0001, 0, r, spd(r)));
                exp_q.push_back(mk(4'b0100, 0, r, spd(r)));
            end else begin
                exp_q.push_back(mk(4'b0100, i + 1, r, spd(r)));
            end
            do_pulse();
        end
        tick(2);
        chk("player_entry", 32'(player_turn), 1);
    endtask

    // From PLAYER: enter r colours, the one at fail_at being wrong
    task automatic enter(input int r, input int fail_at);
        for (int i = 0; i < r; i++) begin
            chk("player_turn", 32'(player_turn), 1);
            chk("player_cr",   32'(check_round), 32'(i));
            if (i == fail_at) begin
                result = 1'b0;
                do_press();
                chk("check_turn", 32'(player_turn), 0);
                chk("check_over", 32'(game_over), 0);
                tick(1);
                chk("lose_over", 32'(game_over), 1);
                chk("lose_turn", 32'(player_turn), 0);
                result = 1'b1;
                return;
            end
            if (i < r - 1) exp_q.push_back(mk(4'b0100, i + 1, r, spd(r)));
            do_press();
            chk("check_turn", 32'(player_turn), 0);
            tick(1);
            if (i < r - 1) tick(1);
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; press_valid = 1'b0; pulse = 1'b0; result = 1'b1;
        tick(2);
        chk_reset_vals("rst");
        reset = 1'b0;

        // IDLE ignores presses and timer ticks
        press_valid = 1'b1; pulse = 1'b1; @(negedge clk); press_valid = 1'b0; pulse = 1'b0;
        chk("idle_turn",  32'(player_turn), 0);
        chk("idle_round", 32'(round), 0);

        // Reset in the middle of SHOW_ON
        start_game();
        exp_q.push_back(mk(4'b0011, 0, 1, spd(1)));
        exp_q.push_back(mk(4'b0100, 0, 1, spd(1)));
        tick(2);
        chk("pre_rst_flash", 32'(flash_clk), 1);
        tick(1);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;

        // Timeout: eighth unanswered pulse loses
        start_game();
        replay(1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            do_pulse();
            if (k < 8) chk("to_wait_turn", 32'(player_turn), 1);
        end
        chk("to_lose_over", 32'(game_over), 1);
        chk("to_lose_turn", 32'(player_turn), 0);
        chk("lose_flash0", 32'(flash_clk), 0);
        do_pulse();
        chk("lose_flash1", 32'(flash_clk), 1);
        do_press();
        chk("lose_press_over",  32'(game_over), 1);
        chk("lose_press_flash", 32'(flash_clk), 1);

        // Press on the eighth pulse wins; then a wrong second entry in round 2
        start_game();
        replay(1, 1'b0);
        for (int k = 1; k < 8; k++) do_pulse();
        press_valid = 1'b1; pulse = 1'b1; @(negedge clk); press_valid = 1'b0; pulse = 1'b0;
        chk("race_turn", 32'(player_turn), 0);
        chk("race_over", 32'(game_over), 0);
        tick(1);
        replay(2, 1'b0);
        enter(2, 1);

        // Full game to MAX_ROUND, with ignored go/press during the first replay
        start_game();
        for (int r = 1; r <= int'(MAX_ROUND); r++) begin
            replay(r, r == 1);
            enter(r, -1);
        end
        chk("win_won",   32'(game_won), 1);
        chk("win_over",  32'(game_over), 0);
        chk("win_round", 32'(round), MAX_ROUND);
        chk("win_speed", 32'(speed), 7);
        do_pulse();
        chk("win_flash1", 32'(flash_clk), 1);
        do_pulse();
        chk("win_flash0", 32'(flash_clk), 0);
        do_press();
        chk("win_press_won", 32'(game_won), 1);

        start_game();
        chk("restart_won",  32'(game_won), 0);
        chk("events_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
